iso14443a_tag_tx: RTL and testbench
===================================

# iso14443a_tag_tx

Tag-side ISO14443-A response transmitter for the HF FPGA image. It takes bytes from the ARM-side byte interface and appends odd parity to each byte. It Manchester-codes the frame at 106 kbit/s (128 carrier cycles per bit) and drives the load-modulation line with the fc/16 (847.5 kHz) subcarrier. It is the counterpart of the reader-side subcarrier edge detector. Its output gates the antenna load switch when the Proxmark simulates a tag.

## Interface
- BIT_CYCLES, 128: carrier cycles per bit; must be a power of two ≥ 32.
- SUB_HALF, 8: carrier cycles per subcarrier half-period; must be a power of two; BIT_CYCLES/2 must be a multiple of 2·SUB_HALF.
- ck_1356meg  input  1  13.56 MHz carrier clock; all logic on its rising edge.
- rst  input  1  reset, asynchronous, active-high.
- tx_data  input  8  byte to send, LSB first.
- tx_last  input  1  qualifies tx_data: this byte ends the frame.
- tx_valid  input  1  tx_data/tx_last valid.
- tx_ready  output  1  holding buffer empty; a byte is accepted on any edge where tx_valid & tx_ready.
- mod_out  output  1  load-modulation drive; 1 = load on.
- busy  output  1  frame in progress (SOF through EOF).
- done  output  1  one-cycle pulse at the end of EOF.
- underrun  output  1  one-cycle pulse when a frame ends because no byte was available.

## Operation
- One-byte holding buffer holds data, last and buf_valid. tx_ready = ~buf_valid. The shifter loads from the buffer and clears buf_valid on the same edge.
- States:
  - IDLE: waits for buf_valid.
  - SOF: one bit, logic 1.
  - DATA: 8 bits, LSB first.
  - PARITY: one bit, odd parity = ~^byte.
  - EOF: one bit period, no modulation.
- Bit cycle counter cyc runs 0..BIT_CYCLES-1 in every non-IDLE state and is held at 0 in IDLE. The state changes on the edge where cyc = BIT_CYCLES-1. A DATA bit index counts 0..7.
- Transitions:
  - IDLE→SOF when buf_valid; the shifter loads and cyc = 0 on that edge.
  - SOF→DATA.
  - DATA→PARITY after bit 7.
  - PARITY→DATA when cur_last = 0 and buf_valid (registered value) at the final PARITY cycle; the shifter reloads.
  - PARITY→EOF when cur_last = 1.
  - PARITY→EOF with an underrun pulse when cur_last = 0 and buf_valid = 0. A byte written on that same edge is too late.
  - EOF→IDLE with a done pulse.
- Manchester coding, with h = cyc[MSB] (second half of the bit) and s = ~cyc[log2(SUB_HALF)] (subcarrier on):
  - logic 1: modulate the first half, so active = ~h.
  - logic 0: modulate the second half, so active = h.
  - mod_next = active & s in SOF, DATA and PARITY; 0 in IDLE and EOF.
- mod_out is mod_next registered, so it lags the state/cyc by one cycle. Each active half holds exactly (BIT_CYCLES/2)/(2·SUB_HALF) subcarrier pulses (4 at defaults), each SUB_HALF cycles high.
- busy is high from the IDLE→SOF edge through the EOF→IDLE edge, exclusive.
- After an underrun, the late byte stays buffered and starts a new frame after IDLE is reached.

## Timing
- Reset values: mod_out = 0, busy = 0, done = 0, underrun = 0, tx_ready = 1, state IDLE, cyc = 0. Reset mid-frame drops mod_out immediately and discards both the buffer and the shifter.
- Accept at edge E0. At E1, IDLE→SOF and tx_ready rises again. At E2, mod_out is first 1.
- Frame of n bytes: busy high for (9n+2)·BIT_CYCLES cycles. done is asserted on the cycle after the last EOF cycle.
- The next byte must be accepted no later than the edge before the final PARITY cycle of the current byte. That leaves a window of ≥ 9·BIT_CYCLES−1 cycles after the previous load.
- A new frame may start on the edge after done if the buffer is full; there is no gap beyond IDLE's one cycle.

## Test plan
- Reset → mod_out = 0, tx_ready = 1, busy = 0. Assert rst mid-DATA → mod_out low the same cycle; the buffer is empty after release.
- Single byte 0x00 with last = 1:
  - SOF = 1, eight bits = 0, parity = 1.
  - Half 1 of bit 0 is silent, half 2 carries 4 pulses of 8 high / 8 low.
  - busy lasts 11·128 = 1408 cycles; one done pulse; no underrun.
- Two bytes 0xA5 (last = 0) then 0x3C (last = 1), the second written during DATA of the first:
  - Bit sequence 1, 10100101 (LSB first), 1, 00111100 (LSB first), 1.
  - busy lasts 20·128 = 2560 cycles.
- Byte 0x01 with last = 0 and no follow-up → PARITY→EOF, underrun pulse, done pulse, busy = 1408 cycles.
- Late write on the final PARITY edge → underrun. That byte then starts a new frame: first mod_out high 2 cycles after the done pulse.
- tx_valid held while buffer full → no acceptance (tx_ready = 0), and tx_data changes are ignored until tx_ready returns.

Source files
------------

// File: rtl/iso14443a_tag_tx.sv
// ISO14443-A tag response transmitter.
// Takes bytes from the ARM-side byte interface and sends them as one frame:
// an SOF bit, then for each byte 8 data bits (LSB first) and an odd parity
// bit, then an unmodulated EOF bit period. Each bit is Manchester coded over
// BIT_CYCLES carrier cycles, and the active half is filled with the fc/16
// subcarrier to drive the antenna load switch.
//
// Ports
//   ck_1356meg  13.56 MHz carrier clock, rising edge
//   rst         asynchronous reset, active high
//   tx_data     byte to send, LSB first
//   tx_last     this byte ends the frame
//   tx_valid    tx_data/tx_last valid
//   tx_ready    holding buffer empty; byte taken when tx_valid & tx_ready
//   mod_out     load-modulation drive, 1 = load on
//   busy        frame in progress, SOF through EOF
//   done        one-cycle pulse after the last EOF cycle
//   underrun    one-cycle pulse when the frame ends for lack of a next byte
//
// state  | meaning
// IDLE   | no frame; waits for a buffered byte
// SOF    | start-of-frame bit, logic 1
// DATA   | 8 data bits of the current byte, LSB first
// PARITY | odd parity bit of the current byte
// EOF    | one bit period without modulation

module iso14443a_tag_tx #(
  parameter int BIT_CYCLES = 128,
  parameter int SUB_HALF   = 8
) (
  input  logic       ck_1356meg,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_last,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       mod_out,
  output logic       busy,
  output logic       done,
  output logic       underrun
);

  localparam int            CW       = $clog2(BIT_CYCLES);
  localparam int            SB       = $clog2(SUB_HALF);
  localparam logic [CW-1:0] CYC_LAST = CW'(BIT_CYCLES - 1);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SOF    = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_EOF    = 3'd4;

  logic [2:0]    state;
  logic [CW-1:0] cyc;
  logic [2:0]    bit_idx;
  logic [7:0]    buf_data;
  logic          buf_last;
  logic          buf_valid;
  logic [7:0]    cur_byte;
  logic          cur_last;

  logic          accept;
  logic          bit_end;
  logic          load;
  logic          cur_bit;
  logic          coded;
  logic          mod_next;

  assign tx_ready = ~buf_valid;
  assign accept   = tx_valid & ~buf_valid;
  assign bit_end  = (cyc == CYC_LAST);
  assign busy     = (state != ST_IDLE);

  // The shifter takes the buffered byte either to open a frame or to chain
  // straight on after a parity bit; in both cases the buffer empties.
  assign load = ((state == ST_IDLE) & buf_valid) |
                ((state == ST_PARITY) & bit_end & ~cur_last & buf_valid);

  always_comb begin
    cur_bit = 1'b0;
    case (state)
      ST_SOF:    cur_bit = 1'b1;
      ST_DATA:   cur_bit = cur_byte[bit_idx];
      ST_PARITY: cur_bit = ~^cur_byte;
      default:   cur_bit = 1'b0;
    endcase
  end

  // Logic 1 modulates the first half of the bit, logic 0 the second half.
  // cyc[SB] low marks the high phase of the subcarrier.
  assign coded    = cur_bit ? ~cyc[CW-1] : cyc[CW-1];
  assign mod_next = coded & ~cyc[SB] &
                    ((state == ST_SOF) | (state == ST_DATA) | (state == ST_PARITY));

  always_ff @(posedge ck_1356meg or posedge rst) begin
    if (rst) begin
      buf_data  <= '0;
      buf_last  <= 1'b0;
      buf_valid <= 1'b0;
    end else if (accept) begin
      buf_data  <= tx_data;
      buf_last  <= tx_last;
      buf_valid <= 1'b1;
    end else if (load) begin
      buf_valid <= 1'b0;
    end
  end

  always_ff @(posedge ck_1356meg or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      cyc      <= '0;
      bit_idx  <= '0;
      cur_byte <= '0;
      cur_last <= 1'b0;
      mod_out  <= 1'b0;
      done     <= 1'b0;
      underrun <= 1'b0;
    end else begin
      done     <= 1'b0;
      underrun <= 1'b0;
      mod_out  <= mod_next;

      if (load) begin
        cur_byte <= buf_data;
        cur_last <= buf_last;
      end

      if (state == ST_IDLE) cyc <= '0;
      else                  cyc <= cyc + 1'b1;

      case (state)
        ST_IDLE: begin
          if (buf_valid) state <= ST_SOF;
        end
        ST_SOF: begin
          if (bit_end) begin
            state   <= ST_DATA;
            bit_idx <= '0;
          end
        end
        ST_DATA: begin
          if (bit_end) begin
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) state <= ST_PARITY;
          end
        end
        ST_PARITY: begin
          if (bit_end) begin
            if (cur_last) begin
              state <= ST_EOF;
            end else if (buf_valid) begin
              state   <= ST_DATA;
              bit_idx <= '0;
            end else begin
              // Next byte missed its slot; a write landing on this same edge
              // stays buffered and opens the following frame.
              state    <= ST_EOF;
              underrun <= 1'b1;
            end
          end
        end
        ST_EOF: begin
          if (bit_end) begin
            state <= ST_IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iso14443a_tag_tx.sv
module tb_iso14443a_tag_tx;

  localparam int BIT_CYCLES = 128;
  localparam int SUB_HALF   = 8;

  logic       ck_1356meg = 1'b0;
  logic       rst;
  logic [7:0] tx_data;
  logic       tx_last;
  logic       tx_valid;
  logic       tx_ready;
  logic       mod_out;
  logic       busy;
  logic       done;
  logic       underrun;

  int checks = 0;
  int fails  = 0;

  // Scoreboard: per frame the number of coded bits (SOF + 9 per byte),
  // the expected underrun flag, and the flat expected bit stream.
  int         sb_len_q[$];
  bit         sb_under_q[$];
  bit         sb_bit_q[$];
  logic [7:0] fb[$];

  bit wave_q[$];
  int under_cnt = 0;
  bit prev_busy = 1'b0;
  int frame_no  = 0;

  iso14443a_tag_tx #(
    .BIT_CYCLES(BIT_CYCLES),
    .SUB_HALF  (SUB_HALF)
  ) dut (
    .ck_1356meg(ck_1356meg),
    .rst       (rst),
    .tx_data   (tx_data),
    .tx_last   (tx_last),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .mod_out   (mod_out),
    .busy      (busy),
    .done      (done),
    .underrun  (underrun)
  );

  always #5 ck_1356meg = ~ck_1356meg;

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      fails++;
      $display("FAIL %s: got %0d required %0d", name, got, want);
    end
  endtask

  task automatic push_frame(input bit under);
    sb_len_q.push_back(1 + 9 * fb.size());
    sb_under_q.push_back(under);
    sb_bit_q.push_back(1'b1);
    foreach (fb[i]) begin
      for (int b = 0; b < 8; b++) sb_bit_q.push_back(fb[i][b]);
      sb_bit_q.push_back(($countones(fb[i]) % 2) == 0);
    end
    fb.delete();
  endtask

  // Ideal load waveform for cycle c of a bit period.
  function automatic bit exp_mod(input bit b, input bit eof, input int c);
    bit second_half;
    bit sub_on;
    if (eof) return 1'b0;
    second_half = (c >= BIT_CYCLES / 2);
    sub_on      = ((c % (2 * SUB_HALF)) < SUB_HALF);
    return (b ? !second_half : second_half) && sub_on;
  endfunction

  task automatic check_frame();
    int nb;
    bit eu;
    bit bits[$];
    int idx;
    int bad_c;
    bit got;
    bit want;
    bit bad_got;
    bit bad_want;
    checks++;
    if (sb_len_q.size() == 0) begin
      fails++;
      $display("FAIL unexpected_frame: frame of %0d cycles seen, required none", wave_q.size());
    end else begin
      nb = sb_len_q.pop_front();
      eu = sb_under_q.pop_front();
      for (int i = 0; i < nb; i++) bits.push_back(sb_bit_q.pop_front());
      if (wave_q.size() != (nb + 1) * BIT_CYCLES) begin
        fails++;
        $display("FAIL busy_len frame %0d: got %0d required %0d", frame_no, wave_q.size(), (nb + 1) * BIT_CYCLES);
      end
      for (int k = 0; k <= nb; k++) begin
        bad_c    = -1;
        bad_got  = 1'b0;
        bad_want = 1'b0;
        for (int c = 0; c < BIT_CYCLES; c++) begin
          want = exp_mod((k < nb) ? bits[k] : 1'b0, k == nb, c);
          idx  = k * BIT_CYCLES + c;
          got  = (idx < wave_q.size()) ? wave_q[idx] : !want;
          if (got != want && bad_c < 0) begin
            bad_c    = c;
            bad_got  = got;
            bad_want = want;
          end
        end
        checks++;
        if (bad_c >= 0) begin
          fails++;
          $display("FAIL mod_out frame %0d bit %0d cycle %0d: got %0b required %0b", frame_no, k, bad_c, bad_got, bad_want);
        end
      end
      check("underrun_count", under_cnt, int'(eu));
    end
    frame_no++;
    wave_q.delete();
    under_cnt = 0;
  endtask

  // Monitor: mod_out lags the state by one cycle, so the frame waveform is
  // the mod_out samples taken one cycle after each busy sample.
  always @(negedge ck_1356meg) begin
    if (rst) begin
      wave_q.delete();
      under_cnt = 0;
      prev_busy = 1'b0;
    end else begin
      if (prev_busy) wave_q.push_back(mod_out);
      if (underrun) under_cnt++;
      if (done) check_frame();
      prev_busy = busy;
    end
  end

  task automatic send_byte(input logic [7:0] d, input logic l);
    int n;
    n = 0;
    @(negedge ck_1356meg);
    while (!tx_ready && n < 5000) begin
      @(negedge ck_1356meg);
      n++;
    end
    if (!tx_ready) begin
      checks++;
      fails++;
      $display("FAIL send_timeout: tx_ready=%0b required 1", tx_ready);
    end
    tx_data  = d;
    tx_last  = l;
    tx_valid = 1'b1;
    @(posedge ck_1356meg);
    #1;
    tx_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!done && n < 5000) begin
      @(negedge ck_1356meg);
      n++;
    end
    if (!done) begin
      checks++;
      fails++;
      $display("FAIL done_timeout: done=%0b required 1", done);
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((sb_len_q.size() != 0 || busy || !tx_ready) && n < 20000) begin
      @(negedge ck_1356meg);
      n++;
    end
    if (sb_len_q.size() != 0 || busy || !tx_ready) begin
      checks++;
      fails++;
      $display("FAIL drain_timeout: %0d frames outstanding, required 0", sb_len_q.size());
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached with %0d frames outstanding", sb_len_q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    int         nb;
    bit         ur;
    logic [7:0] bs [3];
    logic [7:0] x1, x2, y;
    int         held;
    int         n;

    rst      = 1'b1;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    tx_last  = 1'b0;
    repeat (3) @(negedge ck_1356meg);
    check("reset_mod_out", mod_out, 0);
    check("reset_tx_ready", tx_ready, 1);
    check("reset_busy", busy, 0);
    rst = 1'b0;
    @(negedge ck_1356meg);
    check("idle_busy", busy, 0);
    check("idle_done", done, 0);
    check("idle_underrun", underrun, 0);

    // Single 0x00 byte with first-modulation latency.
    fb.push_back(8'h00);
    push_frame(1'b0);
    send_byte(8'h00, 1'b1);
    @(negedge ck_1356meg);
    check("e0_tx_ready", tx_ready, 0);
    check("e0_busy", busy, 0);
    @(negedge ck_1356meg);
    check("e1_busy", busy, 1);
    check("e1_tx_ready", tx_ready, 1);
    check("e1_mod_out", mod_out, 0);
    @(negedge ck_1356meg);
    check("e2_mod_out", mod_out, 1);
    wait_drain();

    // Two bytes, second written during DATA of the first.
    fb.push_back(8'hA5);
    fb.push_back(8'h3C);
    push_frame(1'b0);
    send_byte(8'hA5, 1'b0);
    repeat (300) @(posedge ck_1356meg);
    send_byte(8'h3C, 1'b1);
    wait_drain();

    // Next byte on the last edge that still chains.
    fb.push_back(8'h5E);
    fb.push_back(8'hC3);
    push_frame(1'b0);
    send_byte(8'h5E, 1'b0);
    repeat (9 * BIT_CYCLES + BIT_CYCLES - 1) @(posedge ck_1356meg);
    send_byte(8'hC3, 1'b1);
    wait_drain();

    // No follow-up byte.
    fb.push_back(8'h01);
    push_frame(1'b1);
    send_byte(8'h01, 1'b0);
    wait_drain();

    // Write landing on the final PARITY edge is too late and opens a new frame.
    fb.push_back(8'h96);
    push_frame(1'b1);
    fb.push_back(8'h2B);
    push_frame(1'b0);
    send_byte(8'h96, 1'b0);
    repeat (10 * BIT_CYCLES) @(posedge ck_1356meg);
    send_byte(8'h2B, 1'b1);
    wait_done();
    @(negedge ck_1356meg);
    check("late_gap1_mod_out", mod_out, 0);
    check("late_gap1_busy", busy, 1);
    @(negedge ck_1356meg);
    check("late_gap2_mod_out", mod_out, 1);
    wait_drain();

    // tx_valid held while the buffer is full.
    x1 = 8'($urandom);
    x2 = 8'($urandom);
    y  = 8'($urandom);
    fb.push_back(x1);
    fb.push_back(x2);
    push_frame(1'b0);
    fb.push_back(y);
    push_frame(1'b0);
    send_byte(x1, 1'b0);
    send_byte(x2, 1'b1);
    held     = 0;
    tx_valid = 1'b1;
    tx_data  = 8'($urandom);
    tx_last  = 1'($urandom);
    for (int i = 0; i < 3000; i++) begin
      @(negedge ck_1356meg);
      if (tx_ready) break;
      held++;
      tx_data = 8'($urandom);
      tx_last = 1'($urandom);
    end
    check("held_ready_low_cycles", held, 10 * BIT_CYCLES - 1);
    tx_data = y;
    tx_last = 1'b1;
    @(posedge ck_1356meg);
    #1;
    tx_valid = 1'b0;
    wait_drain();

    // Reset mid-DATA with a byte buffered.
    send_byte(8'hFF, 1'b0);
    send_byte(8'h77, 1'b1);
    repeat (300) @(negedge ck_1356meg);
    n = 0;
    while (!mod_out && n < 200) begin
      @(negedge ck_1356meg);
      n++;
    end
    check("pre_reset_mod_out", mod_out, 1);
    rst = 1'b1;
    #1;
    check("async_reset_mod_out", mod_out, 0);
    check("async_reset_busy", busy, 0);
    check("async_reset_tx_ready", tx_ready, 1);
    repeat (2) @(negedge ck_1356meg);
    rst = 1'b0;
    repeat (300) @(negedge ck_1356meg);
    check("post_reset_busy", busy, 0);
    check("post_reset_tx_ready", tx_ready, 1);
    check("post_reset_mod_out", mod_out, 0);

    // Randomized frames, some ending in an underrun.
    for (int f = 0; f < 10; f++) begin
      nb = $urandom_range(1, 3);
      ur = ($urandom_range(0, 4) == 0);
      for (int k = 0; k < 3; k++) bs[k] = 8'($urandom);
      for (int k = 0; k < nb; k++) fb.push_back(bs[k]);
      push_frame(ur);
      for (int k = 0; k < nb; k++) begin
        if (k > 0) repeat ($urandom_range(0, 300)) @(posedge ck_1356meg);
        send_byte(bs[k], (k == nb - 1) && !ur);
      end
      if (ur) wait_done();
      else repeat ($urandom_range(0, 400)) @(posedge ck_1356meg);
    end
    wait_drain();
    check("scoreboard_bits_left", sb_bit_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
